// File: rtl/aes_arb_pkg.sv
// -----------------------------------------------------------------------------
// aes_arb_pkg
// Shared types and constants for the AES encryption-core arbiter slice.
//   AES_BLOCK_W  : width of plain text, key and ciphertext blocks
//   arb_state_t  : arbiter FSM states
//   grant_width  : bits needed to hold a requester index
// -----------------------------------------------------------------------------
package aes_arb_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } arb_state_t;

    // Never returns 0 so a single-bit index is still a legal vector.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/aes_enc_arbiter_if.sv
// -----------------------------------------------------------------------------
// aes_enc_arbiter_if
// Request/response fabric and encryption-core signals of the arbiter.
//   req_valid/req_ready/req_text/req_key  : per-requester request channel
//   resp_valid/resp_ready/resp_data/resp_err : shared response bus, one-hot select
//   core_*                                : connection to the encryption core
// Modports:
//   slave  : the arbiter
//   master : requesters plus encryption core (system side)
// -----------------------------------------------------------------------------
interface aes_enc_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]                          req_valid;
    logic [NUM_REQ-1:0]                          req_ready;
    logic [NUM_REQ*aes_arb_pkg::AES_BLOCK_W-1:0] req_text;
    logic [NUM_REQ*aes_arb_pkg::AES_BLOCK_W-1:0] req_key;
    logic [NUM_REQ-1:0]                          resp_valid;
    logic [NUM_REQ-1:0]                          resp_ready;
    logic [aes_arb_pkg::AES_BLOCK_W-1:0]         resp_data;
    logic                                        resp_err;
    logic                                        core_start;
    logic [aes_arb_pkg::AES_BLOCK_W-1:0]         core_plain_text;
    logic [aes_arb_pkg::AES_BLOCK_W-1:0]         core_key;
    logic [aes_arb_pkg::AES_BLOCK_W-1:0]         core_enc_data;
    logic                                        core_valid_flag;

    modport slave (
        input  req_valid, req_text, req_key, resp_ready, core_enc_data, core_valid_flag,
        output req_ready, resp_valid, resp_data, resp_err, core_start, core_plain_text, core_key
    );

    modport master (
        output req_valid, req_text, req_key, resp_ready, core_enc_data, core_valid_flag,
        input  req_ready, resp_valid, resp_data, resp_err, core_start, core_plain_text, core_key
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant plus the rotating priority pointer.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   req_valid_i     : per-requester request valid
//   accept_i        : grant taken this cycle; pointer moves past the winner
//   grant_o         : index of first valid requester at or above the pointer
//   grant_valid_o   : at least one requester is valid
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GW      = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               accept_i,
    output logic [GW-1:0]      grant_o,
    output logic               grant_valid_o
);

    logic [GW-1:0] ptr_q;
    logic [GW-1:0] ptr_d;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            logic [GW:0] idx;
            // One extra bit so ptr+k cannot overflow before the wrap.
            idx = {1'b0, ptr_q} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_REQ)) begin
                idx = idx - (GW+1)'(NUM_REQ);
            end
            if (!grant_valid_o && req_valid_i[idx[GW-1:0]]) begin
                grant_o       = idx[GW-1:0];
                grant_valid_o = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = (grant_o == GW'(NUM_REQ - 1)) ? '0 : grant_o + GW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_enc_arbiter.sv
// -----------------------------------------------------------------------------
// aes_enc_arbiter
// Shares one AES encryption core among NUM_REQ requesters, round-robin.
// One block in flight: accept -> START (core_start pulse) -> WAIT -> RESP.
//   clock, reset : sole clock (rising edge), synchronous active-high reset
//   bus (slave)  : request channels, one-hot response bus, core connection
// Optional feature macro: AES_ARB_TIMEOUT_EN
//   defined   : WAIT watchdog of TIMEOUT_CYCLES, returns resp_err=1, resp_data=0
//   undefined : WAIT is unbounded, resp_err is constant 0
// -----------------------------------------------------------------------------
module aes_enc_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    aes_enc_arbiter_if.slave bus
);

    localparam int unsigned GW = grant_width(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("aes_enc_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state_q;
    logic [GW-1:0]          grant_q;
    logic                   core_start_q;
    logic [AES_BLOCK_W-1:0] core_text_q;
    logic [AES_BLOCK_W-1:0] core_key_q;
    logic [AES_BLOCK_W-1:0] resp_data_q;
    logic [NUM_REQ-1:0]     resp_valid_q;
    logic                   first_wait_q;

    logic [GW-1:0]          arb_grant;
    logic                   arb_valid;
    logic                   accept;

    logic [AES_BLOCK_W-1:0] text_a [NUM_REQ];
    logic [AES_BLOCK_W-1:0] key_a  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign text_a[i] = bus.req_text[i*AES_BLOCK_W +: AES_BLOCK_W];
        assign key_a[i]  = bus.req_key[i*AES_BLOCK_W +: AES_BLOCK_W];
    end

    // Gated by reset so req_ready reads 0 while reset is asserted.
    assign accept = !reset && (state_q == IDLE) && arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_rr (
        .clk_i         (clock),
        .rst_i         (reset),
        .req_valid_i   (bus.req_valid),
        .accept_i      (accept),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_valid)
    );

    assign bus.req_ready       = accept ? (NUM_REQ'(1) << arb_grant) : '0;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_data       = resp_data_q;
    assign bus.core_start      = core_start_q;
    assign bus.core_plain_text = core_text_q;
    assign bus.core_key        = core_key_q;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;
    logic          resp_err_q;
    logic          timeout_hit;

    // Counter holds the number of completed WAIT cycles; this is the limit cycle.
    assign timeout_hit  = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            core_start_q <= 1'b0;
            core_text_q  <= '0;
            core_key_q   <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= '0;
            first_wait_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q      <= arb_grant;
                        core_text_q  <= text_a[arb_grant];
                        core_key_q   <= key_a[arb_grant];
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    first_wait_q <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
                    to_cnt_q     <= '0;
`endif
                    state_q      <= WAIT;
                end
                WAIT: begin
                    first_wait_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
                    to_cnt_q     <= to_cnt_q + TW'(1);
`endif
                    // A flag seen in the first WAIT cycle may be left over from
                    // the previous operation, so it is not taken.
                    if (!first_wait_q && bus.core_valid_flag) begin
                        resp_data_q  <= bus.core_enc_data;
                        resp_valid_q <= NUM_REQ'(1) << grant_q;
`ifdef AES_ARB_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
`endif
                        state_q      <= RESP;
                    end
`ifdef AES_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        resp_data_q  <= '0;
                        resp_valid_q <= NUM_REQ'(1) << grant_q;
                        resp_err_q   <= 1'b1;
                        state_q      <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (bus.resp_ready[grant_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_enc_arbiter
// Bench for aes_enc_arbiter with a behavioural encryption-core stand-in and a
// round-robin reference model. Honors AES_ARB_TIMEOUT_EN for the watchdog test.
// -----------------------------------------------------------------------------
module tb_aes_enc_arbiter;

    localparam int N = 4;
    localparam logic [127:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] JUNK   = 128'hdeaddeaddeaddeaddeaddeaddeaddead;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    logic [127:0] txt_a [N];
    logic [127:0] key_a [N];

    // core stand-in controls
    bit           core_mute  = 1'b0;
    bit           core_stale = 1'b0;
    int           core_lat   = 2;
    bit           c_busy     = 1'b0;
    int           c_cnt      = 0;
    logic [127:0] c_t, c_k;

    aes_enc_arbiter_if #(.NUM_REQ(N)) bus ();

    aes_enc_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Known FIPS-197 vector, otherwise an arbitrary keyed mix.
    function automatic logic [127:0] ref_cipher(input logic [127:0] t, input logic [127:0] k);
        if (t == FIPS_T && k == FIPS_K) return FIPS_C;
        return t ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (model_ptr + k) % N;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // Core stand-in: driven on the falling edge, sampled by the DUT on the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            c_busy = 1'b0;
            bus.core_valid_flag = 1'b0;
            bus.core_enc_data = '0;
        end else if (bus.core_start) begin
            c_busy = 1'b1;
            c_cnt  = core_lat;
            c_t    = bus.core_plain_text;
            c_k    = bus.core_key;
            bus.core_valid_flag = core_stale;
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                c_busy = 1'b0;
                if (!core_mute) begin
                    bus.core_valid_flag = 1'b1;
                    bus.core_enc_data = ref_cipher(c_t, c_k);
                end
            end else begin
                c_cnt = c_cnt - 1;
                bus.core_valid_flag = core_stale;
                if (core_stale) bus.core_enc_data = JUNK;
            end
        end else begin
            bus.core_valid_flag = core_stale;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_text[i*128 +: 128] = txt_a[i];
            bus.req_key[i*128 +: 128]  = key_a[i];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Drives one transaction with the current req_valid and reports what happened.
    task automatic run_txn(input bit drop, output int g, output logic [N-1:0] rdy,
                           output logic [N-1:0] rv, output logic [127:0] d, output logic e,
                           output int starts, output int waits, output logic [127:0] pt,
                           output bit ok);
        g = -1; rdy = '0; rv = '0; d = '0; e = 1'b0;
        starts = 0; waits = 0; pt = '0; ok = 1'b0;
        for (int c = 0; c < 20 && g < 0; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                rdy = bus.req_ready;
                for (int i = 0; i < N; i++) if (bus.req_ready[i]) g = i;
            end
            tick();
        end
        if (g < 0) return;
        if (drop) bus.req_valid[g] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (bus.resp_valid != '0) begin
                rv = bus.resp_valid;
                d  = bus.resp_data;
                e  = bus.resp_err;
                ok = 1'b1;
                break;
            end
            if (bus.core_start) begin
                starts++;
                pt = bus.core_plain_text;
            end else begin
                waits++;
            end
            tick();
        end
        if (ok) begin
            bus.resp_ready = rv;
            tick();
            bus.resp_ready = '0;
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        vectors++; if (bus.resp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_resp_valid: got %b expected 0000", bus.resp_valid); end
        vectors++; if (bus.resp_data !== 128'h0) begin miscompares++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
        vectors++; if (bus.resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
        vectors++; if (bus.core_start !== 1'b0) begin miscompares++; $display("FAIL reset_core_start: got %b expected 0", bus.core_start); end
        vectors++; if (bus.core_plain_text !== 128'h0) begin miscompares++; $display("FAIL reset_core_text: got %h expected 0", bus.core_plain_text); end
        vectors++; if (bus.core_key !== 128'h0) begin miscompares++; $display("FAIL reset_core_key: got %h expected 0", bus.core_key); end
        bus.req_valid = '0;
        rst = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        int g, starts, waits, exp;
        logic [N-1:0] rdy, rv;
        logic [127:0] d, pt;
        logic e;
        bit ok;
        txt_a[0] = FIPS_T;
        key_a[0] = FIPS_K;
        load_reqs();
        core_lat = $urandom_range(1, 6);
        exp = model_pick(4'b0001);
        bus.req_valid = 4'b0001;
        run_txn(1'b1, g, rdy, rv, d, e, starts, waits, pt, ok);
        model_ptr = (exp + 1) % N;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_done: got %b expected 1", ok); end
        vectors++; if (rdy !== 4'b0001) begin miscompares++; $display("FAIL single_req_ready: got %b expected 0001", rdy); end
        vectors++; if (rv !== 4'b0001) begin miscompares++; $display("FAIL single_resp_valid: got %b expected 0001", rv); end
        vectors++; if (d !== FIPS_C) begin miscompares++; $display("FAIL single_resp_data: got %h expected %h", d, FIPS_C); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL single_resp_err: got %b expected 0", e); end
        vectors++; if (starts != 1) begin miscompares++; $display("FAIL single_starts: got %0d expected 1", starts); end
        vectors++; if (pt !== FIPS_T) begin miscompares++; $display("FAIL single_core_text: got %h expected %h", pt, FIPS_T); end
        vectors++; if (waits != core_lat + 1) begin miscompares++; $display("FAIL single_wait_cycles: got %0d expected %0d", waits, core_lat + 1); end
    endtask

    task automatic test_round_robin();
        int g, starts, waits;
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] rdy, rv;
        logic [127:0] d, pt;
        logic e;
        bit ok;
        do_reset();
        for (int i = 0; i < N; i++) begin
            txt_a[i] = rand128();
            key_a[i] = rand128();
        end
        load_reqs();
        bus.req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            core_lat = $urandom_range(1, 5);
            run_txn(1'b0, g, rdy, rv, d, e, starts, waits, pt, ok);
            vectors++; if (g != seq[j]) begin miscompares++; $display("FAIL rr_grant%0d: got %0d expected %0d", j, g, seq[j]); end
            vectors++; if (rv !== 4'(1 << seq[j])) begin miscompares++; $display("FAIL rr_resp_valid%0d: got %b expected %b", j, rv, 4'(1 << seq[j])); end
            vectors++; if (d !== ref_cipher(txt_a[seq[j]], key_a[seq[j]])) begin miscompares++; $display("FAIL rr_data%0d: got %h expected %h", j, d, ref_cipher(txt_a[seq[j]], key_a[seq[j]])); end
            vectors++; if (starts != 1) begin miscompares++; $display("FAIL rr_starts%0d: got %0d expected 1", j, starts); end
        end
        bus.req_valid = '0;
        model_ptr = 1;
        tick();
    endtask

    task automatic test_backpressure();
        bit got, seen;
        logic [127:0] exp_d;
        txt_a[2] = rand128();
        key_a[2] = rand128();
        load_reqs();
        exp_d = ref_cipher(txt_a[2], key_a[2]);
        core_lat = 3;
        bus.req_valid = 4'b0100;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            got = bus.req_ready[2];
            tick();
        end
        bus.req_valid = '0;
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL bp_accept: got %b expected 1", got); end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            #1;
            seen = (bus.resp_valid != '0);
            if (!seen) tick();
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL bp_resp_seen: got %b expected 1", seen); end
        // Other requesters assert and acknowledge while the granted one stalls.
        bus.req_valid  = 4'b1011;
        bus.resp_ready = 4'b1011;
        for (int c = 0; c < 20; c++) begin
            tick();
            #1;
            vectors++; if (bus.resp_valid !== 4'b0100) begin miscompares++; $display("FAIL bp_resp_valid c%0d: got %b expected 0100", c, bus.resp_valid); end
            vectors++; if (bus.resp_data !== exp_d) begin miscompares++; $display("FAIL bp_resp_data c%0d: got %h expected %h", c, bus.resp_data, exp_d); end
            vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_req_ready c%0d: got %b expected 0000", c, bus.req_ready); end
            vectors++; if (bus.core_start !== 1'b0) begin miscompares++; $display("FAIL bp_core_start c%0d: got %b expected 0", c, bus.core_start); end
        end
        bus.req_valid  = '0;
        bus.resp_ready = 4'b0100;
        tick();
        bus.resp_ready = '0;
        #1;
        vectors++; if (bus.resp_valid !== 4'b0000) begin miscompares++; $display("FAIL bp_release: got %b expected 0000", bus.resp_valid); end
        model_ptr = 3;
        tick();
    endtask

    task automatic test_stale_flag();
        int g, starts, waits, k, exp;
        logic [N-1:0] rdy, rv;
        logic [127:0] d, pt;
        logic e;
        bit ok;
        k = $urandom_range(0, N - 1);
        txt_a[k] = rand128();
        key_a[k] = rand128();
        load_reqs();
        core_stale = 1'b1;
        core_lat = 1;
        exp = model_pick(4'(1 << k));
        bus.req_valid = 4'(1 << k);
        run_txn(1'b1, g, rdy, rv, d, e, starts, waits, pt, ok);
        core_stale = 1'b0;
        model_ptr = (exp + 1) % N;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stale_done: got %b expected 1", ok); end
        vectors++; if (g != exp) begin miscompares++; $display("FAIL stale_grant: got %0d expected %0d", g, exp); end
        vectors++; if (waits != 2) begin miscompares++; $display("FAIL stale_wait_cycles: got %0d expected 2", waits); end
        vectors++; if (d !== ref_cipher(txt_a[k], key_a[k])) begin miscompares++; $display("FAIL stale_data: got %h expected %h", d, ref_cipher(txt_a[k], key_a[k])); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int g, starts, waits;
        logic [N-1:0] rdy, rv;
        logic [127:0] d, pt;
        logic e;
        bit ok, got;
        for (int i = 0; i < N; i++) begin
            txt_a[i] = rand128();
            key_a[i] = rand128();
        end
        load_reqs();
        core_mute = 1'b1;
        bus.req_valid = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            got = bus.req_ready[1];
            tick();
        end
        bus.req_valid = '0;
        tick();
        tick();
        vectors++; if (bus.core_plain_text !== txt_a[1]) begin miscompares++; $display("FAIL rstw_core_text_before: got %h expected %h", bus.core_plain_text, txt_a[1]); end
        bus.req_valid = 4'b0100;
        rst = 1'b1;
        tick();
        #1;
        vectors++; if (bus.resp_valid !== 4'b0000) begin miscompares++; $display("FAIL rstw_resp_valid: got %b expected 0000", bus.resp_valid); end
        vectors++; if (bus.resp_data !== 128'h0) begin miscompares++; $display("FAIL rstw_resp_data: got %h expected 0", bus.resp_data); end
        vectors++; if (bus.core_start !== 1'b0) begin miscompares++; $display("FAIL rstw_core_start: got %b expected 0", bus.core_start); end
        vectors++; if (bus.core_plain_text !== 128'h0) begin miscompares++; $display("FAIL rstw_core_text: got %h expected 0", bus.core_plain_text); end
        vectors++; if (bus.core_key !== 128'h0) begin miscompares++; $display("FAIL rstw_core_key: got %h expected 0", bus.core_key); end
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL rstw_req_ready: got %b expected 0000", bus.req_ready); end
        rst = 1'b0;
        core_mute = 1'b0;
        model_ptr = 0;
        core_lat = $urandom_range(1, 4);
        run_txn(1'b1, g, rdy, rv, d, e, starts, waits, pt, ok);
        model_ptr = 3;
        vectors++; if (g != 2) begin miscompares++; $display("FAIL rstw_fresh_grant: got %0d expected 2", g); end
        vectors++; if (d !== ref_cipher(txt_a[2], key_a[2])) begin miscompares++; $display("FAIL rstw_fresh_data: got %h expected %h", d, ref_cipher(txt_a[2], key_a[2])); end
        vectors++; if (starts != 1) begin miscompares++; $display("FAIL rstw_fresh_starts: got %0d expected 1", starts); end
        tick();
    endtask

    task automatic test_random();
        int g, starts, waits, exp;
        logic [N-1:0] rdy, rv, mask;
        logic [127:0] d, pt;
        logic e;
        bit ok;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N; i++) begin
                txt_a[i] = rand128();
                key_a[i] = rand128();
            end
            load_reqs();
            mask = 4'($urandom_range(1, 15));
            core_lat = $urandom_range(1, 6);
            exp = model_pick(mask);
            bus.req_valid = mask;
            run_txn(1'b0, g, rdy, rv, d, e, starts, waits, pt, ok);
            bus.req_valid = '0;
            model_ptr = (exp + 1) % N;
            vectors++; if (g != exp) begin miscompares++; $display("FAIL rand%0d_grant mask=%b: got %0d expected %0d", it, mask, g, exp); end
            vectors++; if (rdy !== 4'(1 << exp)) begin miscompares++; $display("FAIL rand%0d_req_ready: got %b expected %b", it, rdy, 4'(1 << exp)); end
            vectors++; if (d !== ref_cipher(txt_a[exp], key_a[exp])) begin miscompares++; $display("FAIL rand%0d_data: got %h expected %h", it, d, ref_cipher(txt_a[exp], key_a[exp])); end
            vectors++; if (pt !== txt_a[exp]) begin miscompares++; $display("FAIL rand%0d_core_text: got %h expected %h", it, pt, txt_a[exp]); end
            vectors++; if (starts != 1) begin miscompares++; $display("FAIL rand%0d_starts: got %0d expected 1", it, starts); end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

`ifdef AES_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g, starts, waits, exp;
        logic [N-1:0] rdy, rv;
        logic [127:0] d, pt;
        logic e;
        bit ok;
        txt_a[3] = rand128();
        key_a[3] = rand128();
        load_reqs();
        core_mute = 1'b1;
        core_lat = 2;
        exp = model_pick(4'b1000);
        bus.req_valid = 4'b1000;
        run_txn(1'b1, g, rdy, rv, d, e, starts, waits, pt, ok);
        core_mute = 1'b0;
        model_ptr = (exp + 1) % N;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_done: got %b expected 1", ok); end
        vectors++; if (waits != 8) begin miscompares++; $display("FAIL to_wait_cycles: got %0d expected 8", waits); end
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL to_resp_err: got %b expected 1", e); end
        vectors++; if (d !== 128'h0) begin miscompares++; $display("FAIL to_resp_data: got %h expected 0", d); end
        vectors++; if (rv !== 4'b1000) begin miscompares++; $display("FAIL to_resp_valid: got %b expected 1000", rv); end
    endtask
`else
    task automatic test_timeout();
        bit got;
        int resp_seen;
        core_mute = 1'b1;
        core_lat = 2;
        bus.req_valid = 4'b1000;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            #1;
            got = bus.req_ready[3];
            tick();
        end
        bus.req_valid = '0;
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL nto_accept: got %b expected 1", got); end
        resp_seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus.resp_valid != '0) resp_seen++;
        end
        vectors++; if (resp_seen != 0) begin miscompares++; $display("FAIL nto_wait_forever: got %0d resp cycles expected 0", resp_seen); end
        core_mute = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        bus.req_valid       = '0;
        bus.req_text        = '0;
        bus.req_key         = '0;
        bus.resp_ready      = '0;
        bus.core_enc_data   = '0;
        bus.core_valid_flag = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stale_flag();
        test_reset_mid_wait();
        test_random();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
